// File: rtl/tt_um_load_stream_if.sv
// Beat bus carrying bit-plane chunks from the weight source into the loader.
interface tt_um_load_stream_if #(
  parameter int BUS_W = 8
);
  logic [BUS_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tt_um_load_stream.sv
// Streaming ternary weight loader: bit-plane beats build a shadow bank that is
// copied atomically into the active bank driving the MAC array.
module tt_um_load_stream #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int BUS_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(MAX_IN_LEN)-1:0]        cfg_in_last,
  input  logic [$clog2(MAX_OUT_LEN)-1:0]       cfg_out_last,
  tt_um_load_stream_if.slave                   bus,
  output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  uo_weights,
  output logic                                 uo_done,
  output logic                                 uo_busy,
  output logic                                 uo_err
);
  // state  | meaning
  // IDLE   | waiting for start; active bank held
  // MSB    | collecting the sign bit-plane of column col into msb_buf
  // LSB    | pairing the magnitude plane with msb_buf, writing shadow column col
  // COMMIT | copy shadow to active and pulse uo_done
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MSB    = 2'd1;
  localparam logic [1:0] S_LSB    = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam int NCHUNK = MAX_IN_LEN / BUS_W;
  localparam int CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IN_W   = $clog2(MAX_IN_LEN);
  localparam int OUT_W  = $clog2(MAX_OUT_LEN);

  // Row r = chunk*BUS_W + j, so this nesting flattens to entry r*MAX_OUT_LEN+col.
  typedef logic [NCHUNK-1:0][BUS_W-1:0][MAX_OUT_LEN-1:0][1:0] bank_t;

  logic [1:0]                   state;
  logic [CH_W-1:0]              chunk;
  logic [OUT_W-1:0]             col;
  logic [OUT_W-1:0]             out_last_q;
  logic [IN_W-1:0]              in_last_q;
  logic [NCHUNK-1:0][BUS_W-1:0] msb_buf;
  bank_t                        shadow;
  bank_t                        active;
  logic [BUS_W-1:0][1:0]        lsb_code;
  logic                         lsb_err;
  logic                         beat;
  logic                         last_chunk;

  assign bus.in_ready = (state == S_MSB) || (state == S_LSB);
  assign beat         = bus.in_valid & bus.in_ready;
  assign last_chunk   = (chunk == CH_W'(NCHUNK - 1));
  assign uo_busy      = (state != S_IDLE);
  assign uo_weights   = active;

  always_comb begin
    lsb_code = '0;
    lsb_err  = 1'b0;
    for (int j = 0; j < BUS_W; j++) begin
      if ((int'(chunk) * BUS_W + j) > int'(in_last_q)) begin
        lsb_code[j] = 2'b00;
      end else if (msb_buf[chunk][j] && !bus.in_data[j]) begin
        lsb_code[j] = 2'b00;
        lsb_err     = 1'b1;
      end else begin
        lsb_code[j] = {msb_buf[chunk][j], bus.in_data[j]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      chunk      <= '0;
      col        <= '0;
      in_last_q  <= '0;
      out_last_q <= '0;
      msb_buf    <= '0;
      shadow     <= '0;
      active     <= '0;
      uo_done    <= 1'b0;
      uo_err     <= 1'b0;
    end else begin
      uo_done <= 1'b0;
      // start wins over everything, including a beat offered in the same cycle
      if (start) begin
        in_last_q  <= cfg_in_last;
        out_last_q <= cfg_out_last;
        col        <= '0;
        chunk      <= '0;
        uo_err     <= 1'b0;
        state      <= S_MSB;
      end else begin
        case (state)
          S_MSB: begin
            if (beat) begin
              msb_buf[chunk] <= bus.in_data;
              if (last_chunk) begin
                chunk <= '0;
                state <= S_LSB;
              end else begin
                chunk <= chunk + 1'b1;
              end
            end
          end
          S_LSB: begin
            if (beat) begin
              for (int j = 0; j < BUS_W; j++) begin
                shadow[chunk][j][col] <= lsb_code[j];
              end
              if (lsb_err) uo_err <= 1'b1;
              if (last_chunk) begin
                chunk <= '0;
                if (col == out_last_q) begin
                  state <= S_COMMIT;
                end else begin
                  col   <= col + 1'b1;
                  state <= S_MSB;
                end
              end else begin
                chunk <= chunk + 1'b1;
              end
            end
          end
          S_COMMIT: begin
            active  <= shadow;
            uo_done <= 1'b1;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tt_um_load_stream.sv
// Scoreboard bench for tt_um_load_stream: loads push the expected bank, a
// monitor pops and compares on every uo_done.
module tb_tt_um_load_stream;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   cfg_in_last = '0;
  logic [2:0]   cfg_out_last = '0;
  logic [255:0] uo_weights;
  logic         uo_done, uo_busy, uo_err;

  tt_um_load_stream_if #(.BUS_W(8)) bus ();

  tt_um_load_stream dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_in_last  (cfg_in_last),
    .cfg_out_last (cfg_out_last),
    .bus          (bus),
    .uo_weights   (uo_weights),
    .uo_done      (uo_done),
    .uo_busy      (uo_busy),
    .uo_err       (uo_err)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [256:0] exp_q[$];
  logic [255:0] m_shadow = '0;
  logic [255:0] m_active = '0;
  logic [15:0]  msb_p[8];
  logic [15:0]  lsb_p[8];
  int           changed_wo_done = 0;
  int           double_done = 0;
  logic [255:0] prev_w = '0;
  logic         prev_done = 1'b0;
  logic         rst_prev = 1'b1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_col(input int col, input logic [15:0] m, input logic [15:0] l,
                           input int il, inout bit err);
    logic [1:0] c;
    for (int r = 0; r < 16; r++) begin
      c = {m[r], l[r]};
      if (r > il) c = 2'b00;
      else if (c == 2'b10) begin
        c   = 2'b00;
        err = 1'b1;
      end
      m_shadow[2*(r*8+col) +: 2] = c;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input bit gap);
    int n;
    if (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h5A;
      @(posedge clk); #1;
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout got=ready_low exp=ready_high");
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input int il, input int ol, input bit valid_during);
    start        = 1'b1;
    cfg_in_last  = 4'(il);
    cfg_out_last = 3'(ol);
    bus.in_valid = valid_during;
    bus.in_data  = 8'hC3;
    @(posedge clk); #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    cfg_in_last  = 4'($urandom_range(0, 15));
    cfg_out_last = 3'($urandom_range(0, 7));
  endtask

  task automatic run_load(input int il, input int ol, input bit gappy, input bit valid_at_start);
    bit err = 1'b0;
    for (int c = 0; c <= ol; c++) model_col(c, msb_p[c], lsb_p[c], il, err);
    m_active = m_shadow;
    exp_q.push_back({err, m_shadow});
    do_start(il, ol, valid_at_start);
    chk("err_cleared_on_start", 256'(uo_err), 256'(0));
    chk("busy_in_load", 256'(uo_busy), 256'(1));
    for (int c = 0; c <= ol; c++) begin
      send_beat(msb_p[c][7:0],  gappy && ($urandom_range(0, 1) == 1));
      send_beat(msb_p[c][15:8], gappy && ($urandom_range(0, 1) == 1));
      send_beat(lsb_p[c][7:0],  gappy && ($urandom_range(0, 1) == 1));
      send_beat(lsb_p[c][15:8], gappy);
    end
    @(negedge clk);
    chk("done_early", 256'(uo_done), 256'(0));
    @(negedge clk);
    chk("done_latency", 256'(uo_done), 256'(1));
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    logic [256:0] e;
    forever begin
      @(negedge clk);
      if (uo_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=done exp=no_done");
        end else begin
          e = exp_q.pop_front();
          chk("commit_weights", uo_weights, e[255:0]);
          chk("commit_err", 256'(uo_err), 256'(e[256]));
        end
      end
      if (!uo_done && !rst_prev && uo_weights !== prev_w) changed_wo_done++;
      if (uo_done && prev_done) double_done++;
      prev_w    = uo_weights;
      prev_done = uo_done;
      rst_prev  = rst;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_weights", uo_weights, 256'(0));
    chk("rst_done", 256'(uo_done), 256'(0));
    chk("rst_busy", 256'(uo_busy), 256'(0));
    chk("rst_err", 256'(uo_err), 256'(0));
    chk("rst_ready", 256'(bus.in_ready), 256'(0));

    // full load, every entry -1
    for (int c = 0; c < 8; c++) begin msb_p[c] = 16'hFFFF; lsb_p[c] = 16'hFFFF; end
    run_load(15, 7, 1'b0, 1'b0);

    // rows 0-4 of column 0 become +1, others in column 0 zero
    msb_p[0] = 16'h0000; lsb_p[0] = 16'hFFFF;
    run_load(4, 0, 1'b0, 1'b0);

    // illegal code in row 0
    msb_p[0] = 16'h0001; lsb_p[0] = 16'h0000;
    run_load(15, 0, 1'b0, 1'b0);

    // same 16-beat load gap-free, then overwritten, then again with stalls
    msb_p[0] = 16'hF00F; lsb_p[0] = 16'hFFFF;
    msb_p[1] = 16'h0FF0; lsb_p[1] = 16'h00FF;
    msb_p[2] = 16'hAAAA; lsb_p[2] = 16'hFF00;
    msb_p[3] = 16'h5555; lsb_p[3] = 16'h5555;
    run_load(11, 3, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin msb_p[c] = 16'h0000; lsb_p[c] = 16'h0000; end
    run_load(15, 3, 1'b0, 1'b0);
    msb_p[0] = 16'hF00F; lsb_p[0] = 16'hFFFF;
    msb_p[1] = 16'h0FF0; lsb_p[1] = 16'h00FF;
    msb_p[2] = 16'hAAAA; lsb_p[2] = 16'hFF00;
    msb_p[3] = 16'h5555; lsb_p[3] = 16'h5555;
    run_load(11, 3, 1'b1, 1'b0);

    // restart after 3 beats; the aborted load never commits
    do_start(15, 2, 1'b0);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    chk("restart_active_held", uo_weights, m_active);
    msb_p[0] = 16'h00F0; lsb_p[0] = 16'h0F0F;
    msb_p[1] = 16'hC003; lsb_p[1] = 16'hFFFF;
    run_load(9, 1, 1'b0, 1'b1);

    // reset mid-LSB with an illegal code already flagged
    msb_p[0] = 16'h00FF; lsb_p[0] = 16'h0000;
    do_start(15, 0, 1'b0);
    send_beat(msb_p[0][7:0], 1'b0);
    send_beat(msb_p[0][15:8], 1'b0);
    send_beat(lsb_p[0][7:0], 1'b0);
    chk("err_before_rst", 256'(uo_err), 256'(1));
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    m_shadow = '0;
    m_active = '0;
    chk("midrst_weights", uo_weights, 256'(0));
    chk("midrst_done", 256'(uo_done), 256'(0));
    chk("midrst_busy", 256'(uo_busy), 256'(0));
    chk("midrst_err", 256'(uo_err), 256'(0));
    chk("midrst_ready", 256'(bus.in_ready), 256'(0));

    // shadow was cleared by reset, so columns 1-7 commit as zero
    msb_p[0] = 16'h0F0F; lsb_p[0] = 16'hFFFF;
    run_load(15, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", 256'(exp_q.size()), 256'(0));
    chk("weights_stable", 256'(changed_wo_done), 256'(0));
    chk("done_single", 256'(double_done), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
